bird_motion_gen: RTL and testbench

Drives the bird column of the LED playfield. It generates the one-cycle "press" (move up one row) and "gravity" (move down one row) step pulses that every bird-column cell consumes. It uses the player key, a periodic fall timer, and the column's top/bottom occupancy flags, and it also runs the game-level IDLE/PLAY/CRASH sequencing. It sits between the key input path and the bird column; its press/gravity outputs fan out to all column cells.

---
 rtl/bird_motion_gen_if.sv | 21 ++
 rtl/bird_motion_gen.sv | 83 ++++++++
 tb/tb_bird_motion_gen.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bird_motion_gen_if.sv
// Bird-column control bundle: key and occupancy flags in, step pulses and game status out.
interface bird_motion_gen_if;
   logic key;
   logic bird_top;
   logic bird_bottom;
   logic hit;
   logic press;
   logic gravity;
   logic playing;
   logic crashed;

   modport master (
      output key, bird_top, bird_bottom, hit,
      input  press, gravity, playing, crashed
   );

   modport slave (
      input  key, bird_top, bird_bottom, hit,
      output press, gravity, playing, crashed
   );
endinterface

// File: rtl/bird_motion_gen.sv
// Bird motion generator: flap/gravity step pulses for the bird column and IDLE/PLAY/CRASH game sequencing.
module bird_motion_gen #(
   parameter int GRAV_PERIOD = 8,
   parameter int CNT_W       = 4
) (
   input  logic                clk,
   input  logic                reset,
   bird_motion_gen_if.slave    bird_if
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_CRASH = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TICK_VAL = CNT_W'(GRAV_PERIOD - 1);

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_key_q;
   logic              r_press, r_gravity, r_playing, r_crashed;
   logic              w_press_nxt, w_gravity_nxt;
   logic              w_flap, w_tick;

   assign w_flap = bird_if.key & ~r_key_q;
   assign w_tick = (r_cnt == TICK_VAL);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_key_q   <= 1'b0;
         r_press   <= 1'b0;
         r_gravity <= 1'b0;
         r_playing <= 1'b0;
         r_crashed <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_key_q   <= bird_if.key;
         r_press   <= w_press_nxt;
         r_gravity <= w_gravity_nxt;
         r_playing <= (w_state_nxt == S_PLAY);
         r_crashed <= (w_state_nxt == S_CRASH);
      end
   end

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_flap) w_state_nxt = S_PLAY;
         S_PLAY:  if (bird_if.hit || (w_tick && !w_flap && bird_if.bird_bottom))
                     w_state_nxt = S_CRASH;
         S_CRASH: if (w_flap) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pulses and the fall timer only advance while PLAY persists; any transition restarts cnt at 0.
   always_comb begin
      w_press_nxt   = 1'b0;
      w_gravity_nxt = 1'b0;
      w_cnt_nxt     = '0;
      if (r_state == S_PLAY && w_state_nxt == S_PLAY) begin
         if (w_flap && !bird_if.bird_top) begin
            w_press_nxt = 1'b1;
         end else if (w_tick) begin
            w_gravity_nxt = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
   end

   assign bird_if.press   = r_press;
   assign bird_if.gravity = r_gravity;
   assign bird_if.playing = r_playing;
   assign bird_if.crashed = r_crashed;

endmodule

// File: tb/tb_bird_motion_gen.sv
// Testbench for bird_motion_gen: directed vector table, deadline-based reference model under random stimulus, async reset cases.
module tb_bird_motion_gen;

   localparam int P = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   bird_motion_gen_if bif ();

   bird_motion_gen #(.GRAV_PERIOD(P), .CNT_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .bird_if (bif)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         key;
      bit         top;
      bit         bot;
      bit         hit;
      logic [3:0] exp;   // {press, gravity, playing, crashed}
   } vec_t;

   vec_t tbl[$];

   // Reference model: game mode plus the absolute edge number at which gravity is next due.
   typedef enum {M_IDLE, M_PLAY, M_CRASH} mode_t;
   mode_t m_mode;
   int    edge_n;
   int    deadline;
   bit    prev_key;
   bit    m_press, m_grav;

   task automatic model_reset();
      m_mode   = M_IDLE;
      prev_key = 1'b0;
      m_press  = 1'b0;
      m_grav   = 1'b0;
      edge_n   = 0;
      deadline = 0;
   endtask

   task automatic model_edge(input bit k, input bit t, input bit b, input bit h);
      bit flap = k && !prev_key;
      bit due;
      prev_key = k;
      edge_n++;
      due     = (edge_n == deadline);
      m_press = 1'b0;
      m_grav  = 1'b0;
      case (m_mode)
         M_IDLE: if (flap) begin
            m_mode   = M_PLAY;
            deadline = edge_n + P;
         end
         M_PLAY: begin
            if (h)                    m_mode = M_CRASH;
            else if (due && !flap && b) m_mode = M_CRASH;
            else if (flap && !t) begin
               m_press  = 1'b1;
               deadline = edge_n + P;
            end else if (due) begin
               m_grav   = 1'b1;
               deadline = edge_n + P;
            end
         end
         default: if (flap) m_mode = M_IDLE;
      endcase
   endtask

   function automatic logic [3:0] model_outs();
      return {m_press, m_grav, m_mode == M_PLAY, m_mode == M_CRASH};
   endfunction

   function automatic logic [3:0] dut_outs();
      return {bif.press, bif.gravity, bif.playing, bif.crashed};
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got press/grav/play/crash=%b expected %b", name, act, exp);
      end
   endtask

   task automatic step(input bit k, input bit t, input bit b, input bit h);
      bif.key         = k;
      bif.bird_top    = t;
      bif.bird_bottom = b;
      bif.hit         = h;
      @(posedge clk);
      if (reset) model_reset();
      else       model_edge(k, t, b, h);
      #1;
   endtask

   function automatic void add(input bit k, input bit t, input bit b, input bit h, input logic [3:0] e);
      vec_t v;
      v.key = k; v.top = t; v.bot = b; v.hit = h; v.exp = e;
      tbl.push_back(v);
   endfunction

   initial begin
      bit k;
      bif.key = 1'b0; bif.bird_top = 1'b0; bif.bird_bottom = 1'b0; bif.hit = 1'b0;
      model_reset();
      #2 check("reset_state", dut_outs(), 4'b0000);
      #10 reset = 1'b0;

      // Idle with key low, then start and free-fall for 12 edges
      for (int i = 0; i < 5; i++)  add(0, 0, 0, 0, 4'b0000);
      add(1, 0, 0, 0, 4'b0010);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 4'b0010);
         add(0, 0, 0, 0, 4'b0110);
      end
      // Flap on the tick cycle, then key held: one press, gravity 4 edges later
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 4'b0010);
      add(1, 0, 0, 0, 4'b1010);
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 4'b0010);
      add(1, 0, 0, 0, 4'b0110);
      add(1, 0, 0, 0, 4'b0010);
      add(0, 0, 0, 0, 4'b0010);
      add(0, 0, 0, 0, 4'b0010);
      add(0, 0, 0, 0, 4'b0110);
      // Flap at the ceiling is ignored, gravity keeps its phase
      add(0, 1, 0, 0, 4'b0010);
      add(1, 1, 0, 0, 4'b0010);
      add(0, 1, 0, 0, 4'b0010);
      add(0, 1, 0, 0, 4'b0110);
      // Floor only matters at a tick
      add(0, 0, 0, 0, 4'b0010);
      add(0, 0, 1, 0, 4'b0010);
      add(0, 0, 0, 0, 4'b0010);
      add(0, 0, 1, 0, 4'b0001);
      // CRASH ignores hit; flap to IDLE, flap to PLAY, hit beats flap
      add(0, 0, 0, 1, 4'b0001);
      add(1, 0, 0, 0, 4'b0000);
      add(0, 0, 0, 0, 4'b0000);
      add(1, 0, 0, 0, 4'b0010);
      add(0, 0, 0, 0, 4'b0010);
      add(1, 0, 0, 1, 4'b0001);
      add(0, 0, 0, 0, 4'b0001);
      add(1, 0, 0, 0, 4'b0000);
      add(0, 0, 0, 0, 4'b0000);

      foreach (tbl[i]) begin
         step(tbl[i].key, tbl[i].top, tbl[i].bot, tbl[i].hit);
         check($sformatf("vec%0d", i), dut_outs(), tbl[i].exp);
      end

      // Random stimulus against the model, from a fresh reset
      reset = 1'b1;
      step(0, 0, 0, 0);
      check("rand_reset", dut_outs(), model_outs());
      #2 reset = 1'b0;
      k = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) k = ~k;
         step(k, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 23) == 0);
         check($sformatf("rand%0d", i), dut_outs(), model_outs());
      end

      // Async reset asserted mid-cycle while playing
      reset = 1'b1;
      step(0, 0, 0, 0);
      #2 reset = 1'b0;
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      check("start_play", dut_outs(), 4'b0010);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      #3 reset = 1'b1;
      #1 check("async_reset", dut_outs(), 4'b0000);
      model_reset();
      step(1, 0, 0, 0);
      check("reset_held_a", dut_outs(), 4'b0000);
      step(0, 0, 0, 0);
      check("reset_held_b", dut_outs(), 4'b0000);
      #2 reset = 1'b0;
      step(0, 0, 0, 0);
      check("post_reset_idle", dut_outs(), 4'b0000);
      step(1, 0, 0, 0);
      check("restart_play", dut_outs(), 4'b0010);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0);
         check($sformatf("restart_fall%0d", i), dut_outs(), model_outs());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
